// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scanner
//  Purpose  : Matrix keypad scanner. Walks one active-low column at a time,
//             samples active-low rows after a settle dwell, debounces whole
//             scan frames, rejects multi-key chords and reports each new
//             stable single key as row*COLS+col over a valid/ack handshake.
//  Options  : define KEYPAD_AUTOREPEAT_EN to re-emit a held key every
//             REPEAT frames.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_scanner #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SETTLE   = 1,
  parameter int DEBOUNCE = 4,
  parameter int REPEAT   = 8,
  parameter int CODE_W   = $clog2(ROWS*COLS)
) (
  input  logic              clk_1ms,
  input  logic              rst_n,
  input  logic [ROWS-1:0]   row,
  output logic [COLS-1:0]   col,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ack,
  output logic              key_held,
  output logic              key_multi,
  output logic              key_overrun
);

  localparam int c_cidx_w = $clog2(COLS);
  localparam int c_dw_w   = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int c_db_w   = $clog2(DEBOUNCE + 1);

  localparam logic [c_cidx_w-1:0] c_last_col = c_cidx_w'(COLS - 1);
  localparam logic [c_cidx_w-1:0] c_cidx_one = c_cidx_w'(1);
  localparam logic [c_dw_w-1:0]   c_last_dw  = c_dw_w'(SETTLE);
  localparam logic [c_dw_w-1:0]   c_dw_one   = c_dw_w'(1);
  localparam logic [c_db_w-1:0]   c_db_max   = c_db_w'(DEBOUNCE);
  localparam logic [c_db_w-1:0]   c_db_one   = c_db_w'(1);
  localparam logic [COLS-1:0]     c_col_one  = COLS'(1);

  typedef enum logic [1:0] {
    K_NONE   = 2'd0,
    K_SINGLE = 2'd1,
    K_MULTI  = 2'd2
  } kind_t;

  // ---------------------------------------------------------------- scan
  logic                r_run;
  logic [c_cidx_w-1:0] r_col_idx;
  logic [c_dw_w-1:0]   r_dwell;
  logic                w_sample;
  logic                w_frame_end;
  logic [c_cidx_w-1:0] w_next_idx;

  assign w_sample    = r_run && (r_dwell == c_last_dw);
  assign w_frame_end = w_sample && (r_col_idx == c_last_col);
  assign w_next_idx  = (r_col_idx == c_last_col) ? '0 : (r_col_idx + c_cidx_one);

  // Column walker: first edge out of reset drives column 0, then each column
  // dwells SETTLE+1 cycles and the row sample happens on its last cycle.
  always_ff @(posedge clk_1ms or negedge rst_n) begin
    if (!rst_n) begin
      r_run     <= 1'b0;
      r_col_idx <= '0;
      r_dwell   <= '0;
      col       <= '1;
    end else if (!r_run) begin
      r_run <= 1'b1;
      col   <= ~c_col_one;
    end else if (w_sample) begin
      r_col_idx <= w_next_idx;
      r_dwell   <= '0;
      col       <= ~(c_col_one << w_next_idx);
    end else begin
      r_dwell <= r_dwell + c_dw_one;
    end
  end

  // ------------------------------------------------------ frame accumulate
  logic [1:0]        r_acc_cnt;
  logic [CODE_W-1:0] r_acc_code;
  logic [1:0]        w_cnt;
  logic [CODE_W-1:0] w_code;

  // Fold the current column's pressed rows into the running frame tally
  always_comb begin
    w_cnt  = r_acc_cnt;
    w_code = r_acc_code;
    for (int r = 0; r < ROWS; r++) begin
      if (!row[r]) begin
        w_cnt  = (w_cnt == 2'd0) ? 2'd1 : 2'd2;
        w_code = CODE_W'(r * COLS + int'(r_col_idx));
      end
    end
  end

  // Frame result; the code is forced to zero unless exactly one key was seen
  // so that result comparisons ignore stale codes.
  kind_t             w_res_kind;
  logic [CODE_W-1:0] w_res_code;
  assign w_res_kind = kind_t'(w_cnt);
  assign w_res_code = (w_cnt == 2'd1) ? w_code : '0;

  // ------------------------------------------------------------ debounce
  kind_t             r_prev_kind;
  logic [CODE_W-1:0] r_prev_code;
  logic [c_db_w-1:0] r_db_cnt;
  kind_t             r_stb_kind;
  logic [CODE_W-1:0] r_stb_code;
  logic              w_same;
  logic [c_db_w-1:0] w_db_next;
  logic              w_change;

  assign w_same    = (w_res_kind == r_prev_kind) && (w_res_code == r_prev_code);
  assign w_db_next = !w_same                ? c_db_one :
                     (r_db_cnt == c_db_max) ? r_db_cnt : (r_db_cnt + c_db_one);
  assign w_change  = (w_db_next == c_db_max) &&
                     ((w_res_kind != r_stb_kind) || (w_res_code != r_stb_code));

  // Accumulate per column, and at frame end update debounce and stable state
  always_ff @(posedge clk_1ms or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_cnt   <= 2'd0;
      r_acc_code  <= '0;
      r_prev_kind <= K_NONE;
      r_prev_code <= '0;
      r_db_cnt    <= '0;
      r_stb_kind  <= K_NONE;
      r_stb_code  <= '0;
      key_held    <= 1'b0;
      key_multi   <= 1'b0;
    end else if (w_sample) begin
      if (w_frame_end) begin
        r_acc_cnt   <= 2'd0;
        r_acc_code  <= '0;
        r_prev_kind <= w_res_kind;
        r_prev_code <= w_res_code;
        r_db_cnt    <= w_db_next;
        if (w_change) begin
          r_stb_kind <= w_res_kind;
          r_stb_code <= w_res_code;
          key_held   <= (w_res_kind == K_SINGLE);
          key_multi  <= (w_res_kind == K_MULTI);
        end
      end else begin
        r_acc_cnt  <= w_cnt;
        r_acc_code <= w_code;
      end
    end
  end

  // --------------------------------------------------------------- events
  logic              w_emit_new;
  logic              w_emit_rep;
  logic              w_emit;
  logic [CODE_W-1:0] w_emit_code;

  assign w_emit_new = w_frame_end && w_change && (w_res_kind == K_SINGLE);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int c_rep_w = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [c_rep_w-1:0] c_rep_last = c_rep_w'(REPEAT - 1);
  localparam logic [c_rep_w-1:0] c_rep_one  = c_rep_w'(1);
  logic [c_rep_w-1:0] r_rep_cnt;

  // Count frames of an unchanged stable single key; restart on each repeat
  always_ff @(posedge clk_1ms or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt <= '0;
    end else if (w_frame_end) begin
      if (w_change || (r_stb_kind != K_SINGLE) || (r_rep_cnt == c_rep_last)) begin
        r_rep_cnt <= '0;
      end else begin
        r_rep_cnt <= r_rep_cnt + c_rep_one;
      end
    end
  end

  assign w_emit_rep = w_frame_end && !w_change && (r_stb_kind == K_SINGLE) &&
                      (r_rep_cnt == c_rep_last);
`else
  assign w_emit_rep = 1'b0;
`endif

  assign w_emit      = w_emit_new || w_emit_rep;
  assign w_emit_code = w_emit_new ? w_res_code : r_stb_code;

  // Valid/ack handshake; an event landing on an unacknowledged key is dropped
  // and flagged, while an ack in the same cycle makes room for it.
  always_ff @(posedge clk_1ms or negedge rst_n) begin
    if (!rst_n) begin
      key_valid   <= 1'b0;
      key_code    <= '0;
      key_overrun <= 1'b0;
    end else if (w_emit) begin
      if (key_valid && !key_ack) begin
        key_overrun <= 1'b1;
      end else begin
        key_valid   <= 1'b1;
        key_code    <= w_emit_code;
        key_overrun <= 1'b0;
      end
    end else if (key_ack && key_valid) begin
      key_valid   <= 1'b0;
      key_overrun <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scanner
//  Purpose  : Self-checking bench for keypad_scanner at default parameters
//             (4x4, SETTLE=1, DEBOUNCE=4, 8-cycle frames). A small keypad
//             model shorts row r low while column c is driven and key
//             r*4+c is pressed.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_scanner;

  logic       clk_1ms = 1'b0;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_held;
  logic       key_multi;
  logic       key_overrun;

  logic [15:0] keys;
  logic        use_raw;
  logic [3:0]  raw_row;
  logic [3:0]  model_row;

  int errors = 0;
  int checks = 0;

  keypad_scanner dut (
    .clk_1ms     (clk_1ms),
    .rst_n       (rst_n),
    .row         (row),
    .col         (col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ack     (key_ack),
    .key_held    (key_held),
    .key_multi   (key_multi),
    .key_overrun (key_overrun)
  );

  always #5 clk_1ms = ~clk_1ms;

  // Keypad matrix model
  always_comb begin
    model_row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col[c]) model_row[r] = 1'b0;
      end
    end
  end
  assign row = use_raw ? raw_row : model_row;

  // Column drive must never have more than one bit low
  always @(negedge clk_1ms) begin
    checks++;
    if ($countones(~col) > 1) begin
      errors++;
      $display("FAIL col_onehot: col=%b has more than one low bit", col);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_1ms);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [3:0] e_col, input logic e_valid,
                         input logic [3:0] e_code, input logic e_held, input logic e_multi,
                         input logic e_ovr);
    chk({name, ".col"},     {4'h0, col},         {4'h0, e_col});
    chk({name, ".valid"},   {7'h0, key_valid},   {7'h0, e_valid});
    chk({name, ".code"},    {4'h0, key_code},    {4'h0, e_code});
    chk({name, ".held"},    {7'h0, key_held},    {7'h0, e_held});
    chk({name, ".multi"},   {7'h0, key_multi},   {7'h0, e_multi});
    chk({name, ".overrun"}, {7'h0, key_overrun}, {7'h0, e_ovr});
  endtask

  typedef struct {
    string       name;
    int          adv;
    logic [15:0] keys;
    logic        ack;
    logic [3:0]  col;
    logic        valid;
    logic [3:0]  code;
    logic        held;
    logic        multi;
    logic        ovr;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input string name, input int adv, input logic [15:0] k,
                         input logic ack, input logic [3:0] c, input logic v,
                         input logic [3:0] code, input logic h, input logic m,
                         input logic o);
    vec_t t;
    t.name = name; t.adv = adv; t.keys = k; t.ack = ack; t.col = c;
    t.valid = v; t.code = code; t.held = h; t.multi = m; t.ovr = o;
    vq.push_back(t);
  endtask

  localparam logic [15:0] K6  = 16'h0040;   // row 1, col 2
  localparam logic [15:0] K9  = 16'h0200;   // row 2, col 1
  localparam logic [15:0] K04 = 16'h0011;   // rows 0 and 1 on col 0

  initial begin
    // Clean press of key 6 from reset release (n = negedges after release)
    add_vec("first_col",   1, K6, 1'b0, 4'b1110, 0, 4'd0, 0, 0, 0); // n=1
    add_vec("col0_dwell",  1, K6, 1'b0, 4'b1110, 0, 4'd0, 0, 0, 0); // n=2
    add_vec("col1",        1, K6, 1'b0, 4'b1101, 0, 4'd0, 0, 0, 0); // n=3
    add_vec("col2",        2, K6, 1'b0, 4'b1011, 0, 4'd0, 0, 0, 0); // n=5
    add_vec("col3",        2, K6, 1'b0, 4'b0111, 0, 4'd0, 0, 0, 0); // n=7
    add_vec("pre_event",  25, K6, 1'b0, 4'b0111, 0, 4'd0, 0, 0, 0); // n=32
    add_vec("event6",      1, K6, 1'b0, 4'b1110, 1, 4'd6, 1, 0, 0); // n=33
    add_vec("valid_hold",  8, K6, 1'b0, 4'b1110, 1, 4'd6, 1, 0, 0); // n=41
    add_vec("ack_clear",   1, K6, 1'b1, 4'b1110, 0, 4'd6, 1, 0, 0); // n=42
    add_vec("pre_release",30, 16'h0, 1'b0, 4'b0111, 0, 4'd6, 1, 0, 0); // n=72
    add_vec("released",    1, 16'h0, 1'b0, 4'b1110, 0, 4'd6, 0, 0, 0); // n=73

    // Reset with random row activity
    rst_n   = 1'b0;
    key_ack = 1'b0;
    keys    = '0;
    use_raw = 1'b1;
    raw_row = 4'($urandom);
    for (int i = 0; i < 3; i++) begin
      raw_row = 4'($urandom);
      tick(1);
    end
    chk_all("reset", 4'b1111, 0, 4'd0, 0, 0, 0);
    use_raw = 1'b0;
    keys    = K6;
    rst_n   = 1'b1;                                   // n=0

    foreach (vq[i]) begin
      keys    = vq[i].keys;
      key_ack = vq[i].ack;
      tick(1);
      key_ack = 1'b0;
      tick(vq[i].adv - 1);
      chk_all(vq[i].name, vq[i].col, vq[i].valid, vq[i].code, vq[i].held,
              vq[i].multi, vq[i].ovr);
    end

    // Bounce: key 6 toggles every frame for 12 frames (n=73 -> 169)
    for (int f = 0; f < 12; f++) begin
      keys = (f % 2 == 0) ? K6 : 16'h0;
      tick(8);
      chk("bounce.valid", {7'h0, key_valid}, 8'h0);
      chk("bounce.held",  {7'h0, key_held},  8'h0);
    end

    // Two keys on column 0: MULTI after 4 frames, cleared after 4 NONE frames
    keys = K04;
    tick(31);                                         // n=200
    chk("multi_pre", {7'h0, key_multi}, 8'h0);
    tick(1);                                          // n=201
    chk_all("multi_set", 4'b1110, 0, 4'd6, 0, 1, 0);
    tick(8);                                          // n=209
    keys = 16'h0;
    tick(31);                                         // n=240
    chk("multi_hold", {7'h0, key_multi}, 8'h1);
    tick(1);                                          // n=241
    chk_all("multi_clr", 4'b1110, 0, 4'd6, 0, 0, 0);

    // Overrun: key 6 pending unacked, then key 9 becomes stable
    keys = K6;
    tick(32);                                         // n=273
    chk_all("ovr_first", 4'b1110, 1, 4'd6, 1, 0, 0);
    keys = K9;
    tick(31);                                         // n=304
    chk("ovr_pre", {7'h0, key_overrun}, 8'h0);
    tick(1);                                          // n=305
    chk_all("ovr_set", 4'b1110, 1, 4'd6, 1, 0, 1);
    keys    = K6;
    key_ack = 1'b1;
    tick(1);                                          // n=306
    key_ack = 1'b0;
    chk("ovr_ack.valid",   {7'h0, key_valid},   8'h0);
    chk("ovr_ack.overrun", {7'h0, key_overrun}, 8'h0);

    // Emit and ack in the same cycle: new code replaces the old, no overrun
    tick(31);                                         // n=337
    chk_all("re_press6", 4'b1110, 1, 4'd6, 1, 0, 0);
    keys = K9;
    tick(31);                                         // n=368
    chk("same_pre.code", {4'h0, key_code}, 8'h6);
    key_ack = 1'b1;
    tick(1);                                          // n=369
    key_ack = 1'b0;
    chk_all("same_cycle", 4'b1110, 1, 4'd9, 1, 0, 0);

    // Reset during frame 3 of a new press; key stays held across reset
    keys = K6;
    tick(20);                                         // n=389
    rst_n = 1'b0;
    tick(1);
    chk_all("mid_reset", 4'b1111, 0, 4'd0, 0, 0, 0);
    tick(2);
    rst_n = 1'b1;                                     // m=0
    tick(32);                                         // m=32
    chk_all("post_rst_pre", 4'b0111, 0, 4'd0, 0, 0, 0);
    tick(1);                                          // m=33
    chk_all("post_rst_evt", 4'b1110, 1, 4'd6, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
